// File: rtl/nubus_master_ng.sv
// NuBus master sequencer: arbitrate, START (address cycle), hold data cycle until ACK, retry/abort/lock.
// Latency: 4 cycles IDLE->ARB->ARB(arbdn)->ADDR->DATA minimum; cpu_done lands on the first cycle back in IDLE/LHOLD.
// Backpressure: waits in IDLE while RQST is asserted; waits in ARB for arbdn, grant, free bus and no START.
module nubus_master_ng #(
  parameter int MAX_RETRY   = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             nub_clkn,
  input  logic             nub_resetn,
  input  logic             nub_rqstn,
  input  logic             nub_startn,
  input  logic             nub_ackn,
  input  logic             nub_tm1n,
  input  logic             nub_tm0n,
  input  logic             arb_grant,
  input  logic             cpu_valid,
  input  logic             cpu_lock,
  input  logic [1:0]       cpu_tm,
  output logic             cpu_done,
  output logic [1:0]       cpu_status,
  output logic [CNT_W-1:0] retry_cnt,
  output logic             arbcy_o,
  output logic             adrcy_o,
  output logic             dtacy_o,
  output logic             owner_o,
  output logic             busy_o,
  output logic             arbdn_o,
  output logic             locked_o,
  output logic             tm1n_o,
  output logic             tm0n_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_LHOLD = 3'd4
  } state_t;

  localparam logic [1:0] ST_TRY_LATER = 2'd3;

  state_t           state, state_nx;
  logic [CNT_W-1:0] tmo_cnt, tmo_nx;
  logic [CNT_W-1:0] retry_nx;
  logic             owner_nx, locked_nx, done_nx;
  logic [1:0]       status_nx;

  // Bus lines are active-low on the pads; work with active-high copies.
  logic       rqst, start, ack;
  logic [1:0] ack_status;
  logic       bus_free, timeout_hit, retry_ok;

  assign rqst        = ~nub_rqstn;
  assign start       = ~nub_startn;
  assign ack         = ~nub_ackn;
  assign ack_status  = {~nub_tm1n, ~nub_tm0n};
  assign bus_free    = ~busy_o | ack;
  // Counter is zero in the first DATA cycle, so TIMEOUT_CYC-1 marks the last allowed cycle.
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign retry_ok    = (retry_cnt < CNT_W'(MAX_RETRY));

  // Next-state and bookkeeping decisions for the sequencer.
  always_comb begin
    state_nx  = state;
    tmo_nx    = tmo_cnt;
    retry_nx  = retry_cnt;
    owner_nx  = owner_o;
    locked_nx = locked_o;
    done_nx   = 1'b0;
    status_nx = cpu_status;
    case (state)
      S_IDLE: begin
        // cpu_done high means cpu_valid still belongs to the request just finished.
        if (cpu_valid && !cpu_done && !rqst) begin
          state_nx = S_ARB;
          retry_nx = '0;
        end
      end
      S_ARB: begin
        if (arbdn_o && arb_grant && bus_free && !start) begin
          state_nx  = S_ADDR;
          owner_nx  = 1'b1;
          locked_nx = cpu_lock;
        end
      end
      S_ADDR: begin
        state_nx = S_DATA;
        tmo_nx   = '0;
      end
      S_DATA: begin
        tmo_nx = tmo_cnt + 1'b1;
        if (ack) begin
          if (ack_status == ST_TRY_LATER && retry_ok) begin
            state_nx = S_ARB;
            retry_nx = retry_cnt + 1'b1;
            owner_nx = 1'b0;
          end else begin
            done_nx   = 1'b1;
            status_nx = ack_status;
            if (locked_o && cpu_lock) begin
              state_nx = S_LHOLD;
            end else begin
              state_nx  = S_IDLE;
              owner_nx  = 1'b0;
              locked_nx = 1'b0;
            end
          end
        end else if (timeout_hit) begin
          done_nx   = 1'b1;
          status_nx = ST_TRY_LATER;
          state_nx  = S_IDLE;
          owner_nx  = 1'b0;
          locked_nx = 1'b0;
        end
      end
      S_LHOLD: begin
        if (cpu_valid && cpu_lock && !cpu_done) begin
          state_nx = S_ADDR;
          retry_nx = '0;
        end else if (!cpu_lock) begin
          state_nx  = S_IDLE;
          owner_nx  = 1'b0;
          locked_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Register state, counters and all pad/debug strobes; strobes follow the next state.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      cpu_done   <= 1'b0;
      cpu_status <= 2'd0;
      arbcy_o    <= 1'b0;
      adrcy_o    <= 1'b0;
      dtacy_o    <= 1'b0;
      owner_o    <= 1'b0;
      busy_o     <= 1'b0;
      arbdn_o    <= 1'b0;
      locked_o   <= 1'b0;
      tm1n_o     <= 1'b1;
      tm0n_o     <= 1'b1;
    end else begin
      state      <= state_nx;
      tmo_cnt    <= tmo_nx;
      retry_cnt  <= retry_nx;
      cpu_done   <= done_nx;
      cpu_status <= status_nx;
      arbcy_o    <= (state_nx == S_ARB);
      adrcy_o    <= (state_nx == S_ADDR);
      dtacy_o    <= (state_nx == S_DATA);
      owner_o    <= owner_nx;
      busy_o     <= (~busy_o & start & ~ack) | (busy_o & ~ack);
      arbdn_o    <= arbcy_o & ~start;
      locked_o   <= locked_nx;
      tm1n_o     <= ~((state_nx == S_ADDR) & cpu_tm[1]);
      tm0n_o     <= ~((state_nx == S_ADDR) & cpu_tm[0]);
    end
  end

endmodule

// File: tb/tb_nubus_master_ng.sv
// Bench for nubus_master_ng: directed scenarios then random transactions against a transaction-level model.
// Latency: model predicts the cpu_done cycle from arbitration, address and data phase lengths.
// Backpressure: bench plays slave, arbiter and a foreign master reacting to the DUT strobes.
module tb_nubus_master_ng;

  localparam int MR = 2;
  localparam int TO = 5;

  logic       nub_clkn = 1'b0;
  logic       nub_resetn, nub_rqstn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic       arb_grant, cpu_valid, cpu_lock;
  logic [1:0] cpu_tm;
  logic       cpu_done;
  logic [1:0] cpu_status;
  logic [7:0] retry_cnt;
  logic       arbcy_o, adrcy_o, dtacy_o, owner_o, busy_o, arbdn_o, locked_o, tm1n_o, tm0n_o;

  int errors = 0;
  int checks = 0;

  // Per-attempt scenario: grant delay, foreign ack cycle (0 = no foreign master), ack delay (TO = none), status.
  int         a_gd[3];
  int         a_fa[3];
  int         a_ackd[3];
  logic [1:0] a_st[3];

  nubus_master_ng #(.MAX_RETRY(MR), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_rqstn(nub_rqstn), .nub_startn(nub_startn),
    .nub_ackn(nub_ackn), .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n), .arb_grant(arb_grant),
    .cpu_valid(cpu_valid), .cpu_lock(cpu_lock), .cpu_tm(cpu_tm), .cpu_done(cpu_done),
    .cpu_status(cpu_status), .retry_cnt(retry_cnt), .arbcy_o(arbcy_o), .adrcy_o(adrcy_o),
    .dtacy_o(dtacy_o), .owner_o(owner_o), .busy_o(busy_o), .arbdn_o(arbdn_o),
    .locked_o(locked_o), .tm1n_o(tm1n_o), .tm0n_o(tm0n_o)
  );

  always #5 nub_clkn = ~nub_clkn;

  task automatic tick();
    @(posedge nub_clkn);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction model: each attempt costs its arbitration length, one address cycle and its data cycles.
  function automatic void model(input int w, input bit from_hold, output int n_att,
                                output int done_cyc, output logic [1:0] st, output int arb_total);
    int cyc, l, d;
    cyc = w + 1;
    n_att = 0;
    arb_total = 0;
    st = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (from_hold && i == 0) l = 0;
      else if (a_fa[i] != 0) begin
        l = 3;
        if (a_fa[i] > l) l = a_fa[i];
        if (a_gd[i] + 1 > l) l = a_gd[i] + 1;
      end else begin
        l = 2;
        if (a_gd[i] + 1 > l) l = a_gd[i] + 1;
      end
      d = (a_ackd[i] < TO) ? a_ackd[i] + 1 : TO;
      cyc += l + 1 + d;
      arb_total += l;
      n_att = i + 1;
      if (a_ackd[i] >= TO) begin st = 2'd3; break; end
      if (a_st[i] == 2'd3 && i < MR) continue;
      st = a_st[i];
      break;
    end
    done_cyc = cyc;
  endfunction

  task automatic set_att(input int i, input int gd, input int fa, input int ackd, input logic [1:0] st);
    a_gd[i] = gd; a_fa[i] = fa; a_ackd[i] = ackd; a_st[i] = st;
  endtask

  task automatic run_txn(input string tag, input logic [1:0] tm, input bit lock, input int w, input bit from_hold);
    int n_att, exp_done, arb_total, arb_k, data_k, n_adr, arb_seen, c, att;
    logic [1:0] exp_st;
    logic e1, e0;
    bit done;
    model(w, from_hold, n_att, exp_done, exp_st, arb_total);
    e1 = ~tm[1];
    e0 = ~tm[0];
    cpu_valid = 1'b1; cpu_tm = tm; cpu_lock = lock;
    nub_rqstn = (w > 0) ? 1'b0 : 1'b1;
    arb_k = 0; data_k = 0; n_adr = 0; arb_seen = 0; c = 0; done = 1'b0;
    while (!done && c < 200) begin
      tick();
      c++;
      nub_rqstn = (c < w) ? 1'b0 : 1'b1;
      nub_startn = 1'b1; nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1; arb_grant = 1'b0;
      if (cpu_done) begin
        done = 1'b1;
        check({tag, ":done_cycle"}, c, exp_done);
        check({tag, ":status"}, cpu_status, exp_st);
        check({tag, ":retry_cnt"}, retry_cnt, n_att - 1);
        check({tag, ":addr_cycles"}, n_adr, n_att);
        check({tag, ":arb_cycles"}, arb_seen, arb_total);
        check({tag, ":dtacy_after"}, dtacy_o, 0);
        check({tag, ":owner_at_done"}, owner_o, lock);
        check({tag, ":locked_at_done"}, locked_o, lock);
      end else if (arbcy_o) begin
        arb_k++; arb_seen++;
        att = (n_adr > 2) ? 2 : n_adr;
        arb_grant = (arb_k > a_gd[att]);
        if (a_fa[att] != 0 && arb_k == 1) nub_startn = 1'b0;
        if (a_fa[att] != 0 && arb_k == a_fa[att]) begin
          nub_ackn = 1'b0;
          check({tag, ":busy_foreign"}, busy_o, 1);
        end
      end else if (adrcy_o) begin
        n_adr++; arb_k = 0; data_k = 0;
        check({tag, ":tm1n_addr"}, tm1n_o, e1);
        check({tag, ":tm0n_addr"}, tm0n_o, e0);
      end else if (dtacy_o) begin
        data_k++;
        att = (n_adr < 1) ? 0 : ((n_adr > 3) ? 2 : n_adr - 1);
        if (data_k == 1) check({tag, ":tm_released"}, {tm1n_o, tm0n_o}, 3);
        if (data_k == a_ackd[att] + 1) begin
          nub_ackn = 1'b0;
          nub_tm1n = ~a_st[att][1];
          nub_tm0n = ~a_st[att][0];
        end
      end
    end
    if (!done) check({tag, ":no_cpu_done"}, 0, 1);
    tick();
    check({tag, ":done_pulse"}, cpu_done, 0);
    check({tag, ":no_reaccept"}, {arbcy_o, adrcy_o}, 0);
    check({tag, ":owner_after"}, owner_o, lock);
    cpu_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int n;
    nub_resetn = 1'b0; nub_rqstn = 1'b1; nub_startn = 1'b1; nub_ackn = 1'b1;
    nub_tm1n = 1'b1; nub_tm0n = 1'b1; arb_grant = 1'b0;
    cpu_valid = 1'b0; cpu_lock = 1'b0; cpu_tm = 2'b00;
    for (int i = 0; i < 3; i++) set_att(i, 0, 0, 0, 2'd0);
    repeat (3) tick();
    check("rst:strobes", {arbcy_o, adrcy_o, dtacy_o, owner_o, busy_o, arbdn_o, locked_o}, 0);
    check("rst:tm", {tm1n_o, tm0n_o}, 3);
    check("rst:done", cpu_done, 0);
    check("rst:status", cpu_status, 0);
    check("rst:retry", retry_cnt, 0);
    nub_resetn = 1'b1;
    tick();

    // Single write, immediate grant and ack.
    set_att(0, 0, 0, 0, 2'd0);
    run_txn("write", 2'b10, 1'b0, 0, 1'b0);

    // Foreign master owns the bus during our arbitration.
    set_att(0, 0, 4, 1, 2'd0);
    run_txn("busy", 2'b01, 1'b0, 0, 1'b0);

    // Try-again-later three times: two retries then give up.
    for (int i = 0; i < 3; i++) set_att(i, 0, 0, 0, 2'd3);
    run_txn("retry", 2'b11, 1'b0, 0, 1'b0);

    // No ack: local timeout.
    set_att(0, 0, 0, TO, 2'd0);
    run_txn("timeout", 2'b00, 1'b0, 0, 1'b0);

    // Ack on the last allowed DATA cycle wins over the timeout.
    set_att(0, 0, 0, TO - 1, 2'd1);
    run_txn("ack_at_limit", 2'b00, 1'b0, 0, 1'b0);

    // Reset while the data cycle is open.
    set_att(0, 0, 0, TO, 2'd0);
    cpu_valid = 1'b1; cpu_tm = 2'b11; arb_grant = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (dtacy_o) seen = 1'b1;
    end
    check("rst_mid:reached_data", seen, 1);
    nub_resetn = 1'b0; cpu_valid = 1'b0; arb_grant = 1'b0;
    tick();
    check("rst_mid:strobes", {arbcy_o, adrcy_o, dtacy_o, owner_o, busy_o, arbdn_o, locked_o}, 0);
    check("rst_mid:tm", {tm1n_o, tm0n_o}, 3);
    check("rst_mid:done", cpu_done, 0);
    nub_resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_done) n++;
    end
    check("rst_mid:no_done_later", n, 0);

    // Locked pair: one arbitration, second address cycle straight from the hold state.
    set_att(0, 0, 0, 0, 2'd0);
    run_txn("lock1", 2'b01, 1'b1, 0, 1'b0);
    run_txn("lock2", 2'b10, 1'b1, 0, 1'b1);
    check("lock:held", locked_o, 1);
    cpu_lock = 1'b0;
    tick();
    check("lock:owner_released", owner_o, 0);
    check("lock:locked_released", locked_o, 0);
    tick();

    // Random unlocked transactions.
    for (int t = 0; t < 40; t++) begin
      int r;
      for (int i = 0; i < 3; i++) begin
        r = $urandom_range(0, 5);
        set_att(i, $urandom_range(0, 3), (r < 2) ? 0 : r, $urandom_range(0, TO), 2'($urandom_range(0, 3)));
      end
      run_txn($sformatf("rnd%0d", t), 2'($urandom_range(0, 3)), 1'b0, $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
